// File: rtl/jk_sync_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_sync_counter_if
//  Description : Control and status bundle for jk_sync_counter.
//                - The master side drives enable, direction, load and load data.
//                - The slave side (the counter) returns the count, its
//                  complement, the terminal-count flag and the wrap pulse.
//  Revision    : 1.0  initial release
// ============================================================================
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  // Controller side: issues commands and observes the count.
  modport master (
    output enable,
    output up,
    output load,
    output din,
    input  q,
    input  qbar,
    input  tc,
    input  wrap
  );

  // Counter side: consumes commands and presents the count.
  modport slave (
    input  enable,
    input  up,
    input  load,
    input  din,
    output q,
    output qbar,
    output tc,
    output wrap
  );
endinterface : jk_sync_counter_if
`default_nettype wire

// File: rtl/jk_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jk_sync_counter
//  Description : Synchronous modulo-MODULUS up/down counter.
//                - One JK flip-flop stage per count bit.
//                - Counting drives each stage as a toggle cell (J=K=T).
//                - Loading drives each stage as a D cell (J=D, K=~D).
//                - Outputs are the count, its complement, a combinational
//                  terminal-count flag for cascading and a registered
//                  one-cycle wrap pulse.
//                - Optional build macro JK_CNT_SAT_EN selects saturating mode:
//                  the count sticks at the ends and wrap is tied low.
//                - MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  wire                clk,
  input  wire                clr,    // asynchronous, active-low
  jk_sync_counter_if.slave   bus
);

  // Highest legal count value and modulus, sized for comparisons.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // Register outputs of the JK stages, gathered into one count vector.
  logic [WIDTH-1:0] cnt_q;

  // Next count for the counting path (not used while loading).
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_evt;

  // Load value after clamping out-of-range data to the top count.
  logic             din_over;
  logic [WIDTH-1:0] load_val;

  // Per-stage JK drive.
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;

  // End-of-range detection.
  logic at_max;
  logic at_zero;

  assign at_max  = (cnt_q == MAX_VAL);
  assign at_zero = (cnt_q == '0);

  assign din_over = ({1'b0, bus.din} >= MOD_EXT);
  assign load_val = din_over ? MAX_VAL : bus.din;

  // Counting next state: modulo MODULUS, or saturating when built that way.
  always_comb begin
    cnt_d    = cnt_q;
    wrap_evt = 1'b0;
    if (bus.up) begin
      if (at_max) begin
`ifdef JK_CNT_SAT_EN
        cnt_d    = cnt_q;
`else
        cnt_d    = '0;
        wrap_evt = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      if (at_zero) begin
`ifdef JK_CNT_SAT_EN
        cnt_d    = cnt_q;
`else
        cnt_d    = MAX_VAL;
        wrap_evt = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // JK drive: load uses D-style set/reset codes, counting uses pure toggles
  // on exactly the bits that change, and hold leaves every stage at J=K=0.
  always_comb begin
    jk_j = '0;
    jk_k = '0;
    if (bus.load) begin
      jk_j = load_val;
      jk_k = ~load_val;
    end else if (bus.enable) begin
      jk_j = cnt_d ^ cnt_q;
      jk_k = cnt_d ^ cnt_q;
    end
  end

  // One JK flip-flop per count bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      logic bit_q;

      // JK cell: 01 resets, 10 sets, 11 toggles, 00 holds.
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          bit_q <= 1'b0;
        end else begin
          case ({jk_j[gi], jk_k[gi]})
            2'b01:   bit_q <= 1'b0;
            2'b10:   bit_q <= 1'b1;
            2'b11:   bit_q <= ~bit_q;
            default: bit_q <= bit_q;
          endcase
        end
      end

      assign cnt_q[gi] = bit_q;
    end
  endgenerate

`ifdef JK_CNT_SAT_EN
  // Saturating mode never wraps.
  logic unused_wrap_evt;
  assign unused_wrap_evt = wrap_evt;
  assign bus.wrap        = 1'b0;
`else
  logic wrap_q;

  // Wrap pulse: high for the one cycle after a counting edge that wrapped.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= ~bus.load & bus.enable & wrap_evt;
    end
  end

  assign bus.wrap = wrap_q;
`endif

  assign bus.q    = cnt_q;
  assign bus.qbar = ~cnt_q;

  // Terminal count is live in the current cycle so it can enable the next
  // cascaded counter for the same edge.
  assign bus.tc   = bus.enable & ((bus.up & at_max) | (~bus.up & at_zero));

endmodule : jk_sync_counter
`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_sync_counter
//  Description : Randomised and directed stimulus for jk_sync_counter with a
//                queue-based scoreboard and an integer reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jk_sync_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  typedef struct {
    int unsigned q;
    bit          wrap;
    bit          tc;
  } exp_t;

  logic clk;
  logic clr;

  jk_sync_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_sync_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          drv_done = 1'b0;

  // Reference model state.
  int unsigned m_q    = 0;
  bit          m_wrap = 1'b0;

  // Apply one cycle of inputs (called just after a rising edge), record the
  // expected outputs for the monitor, then advance the model across the edge.
  task automatic step(input bit en, input bit u, input bit ld, input int unsigned d);
    exp_t e;
    bus.enable = en;
    bus.up     = u;
    bus.load   = ld;
    bus.din    = d[WIDTH-1:0];
    e.q    = m_q;
    e.wrap = m_wrap;
    e.tc   = en && ((u && m_q == MODULUS - 1) || (!u && m_q == 0));
    sb.push_back(e);
    @(posedge clk);
    if (!clr) begin
      m_q    = 0;
      m_wrap = 1'b0;
    end else if (ld) begin
      m_q    = (d >= MODULUS) ? MODULUS - 1 : d;
      m_wrap = 1'b0;
    end else if (en) begin
      int nxt;
      nxt = int'(m_q) + (u ? 1 : -1);
      if (nxt < 0 || nxt >= MODULUS) begin
`ifdef JK_CNT_SAT_EN
        m_wrap = 1'b0;
`else
        m_q    = (nxt + MODULUS) % MODULUS;
        m_wrap = 1'b1;
`endif
      end else begin
        m_q    = nxt;
        m_wrap = 1'b0;
      end
    end else begin
      m_wrap = 1'b0;
    end
    #1;
  endtask

  // Drop clr asynchronously between edges; the model resets at once.
  task automatic assert_clr();
    clr    = 1'b0;
    m_q    = 0;
    m_wrap = 1'b0;
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    logic [WIDTH-1:0] eq;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        eq = e.q[WIDTH-1:0];
        checks++;
        if (bus.q !== eq) begin
          errors++;
          $display("FAIL q: got %0d expected %0d at %0t", bus.q, eq, $time);
        end
        checks++;
        if (bus.qbar !== ~eq) begin
          errors++;
          $display("FAIL qbar: got %b expected %b at %0t", bus.qbar, ~eq, $time);
        end
        checks++;
        if (bus.tc !== e.tc) begin
          errors++;
          $display("FAIL tc: got %b expected %b at %0t", bus.tc, e.tc, $time);
        end
        checks++;
        if (bus.wrap !== e.wrap) begin
          errors++;
          $display("FAIL wrap: got %b expected %b at %0t", bus.wrap, e.wrap, $time);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    clr        = 1'b0;
    bus.enable = 1'b0;
    bus.up     = 1'b0;
    bus.load   = 1'b0;
    bus.din    = '0;
    @(posedge clk);
    #1;

    // Reset state: tc only with enable=1 and up=0.
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    clr = 1'b1;

    // Up count across the wrap.
    step(1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 0);

    // Async reset mid-count at 7, then resume counting up.
    step(1'b0, 1'b0, 1'b1, 7);
    step(1'b0, 1'b0, 1'b0, 0);
    assert_clr();
    step(1'b1, 1'b1, 1'b0, 0);
    clr = 1'b1;
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);

    // Down wrap from 0.
    step(1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0);

    // Load priority over enable, clamp of out-of-range data.
    step(1'b1, 1'b1, 1'b1, 13);
    step(1'b1, 1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 1'b1, 15);
    step(1'b1, 1'b1, 1'b1, 10);

    // Hold at 6 while direction toggles.
    step(1'b0, 1'b0, 1'b1, 6);
    for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b0, 0);

    // Ends of range: up from 8, down from 1.
    step(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);

    // Back-to-back direction changes at the ends.
    step(1'b0, 1'b0, 1'b1, 9);
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 59) == 0) assert_clr();
      if (r < 8)       step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b1, $urandom_range(0, 15));
      else if (r < 20) step(1'b0, $urandom_range(0, 1) != 0, 1'b0, $urandom_range(0, 15));
      else             step(1'b1, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 15));
      clr = 1'b1;
    end

    // Let the monitor drain the last expectation.
    drv_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, drv_done=%0b", drv_done);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_jk_sync_counter
`default_nettype wire
